cr16_controller: RTL
====================

# cr16_controller

Multicycle control FSM for the CR16 datapath. It fetches 16-bit instructions over a request/valid port and decodes the R-type, immediate and Bcond formats. It drives the register-file selects, write enable, ALU opcode and immediate mux, latches ALU flags into a PSR, and maintains the PC. It sits between instruction memory and the existing datapath/ALU module, replacing the hard-coded test FSM.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  when low, the FSM holds its state and no side effects occur.
- `imem_valid`  in  1  instruction word on `imem_data` is valid this cycle.
- `imem_data`  in  16  fetched instruction.
- `alu_flags`  in  5  {C,L,F,Z,N} from the ALU, combinational on current selects.
- `imem_req`  out  1  fetch request; `pc` is the address.
- `pc`  out  16  program counter (word address).
- `rf_we`  out  1  register-file write strobe.
- `rf_wsel`, `rf_asel`, `rf_bsel`  out  4 each  destination / A-port / B-port register selects.
- `alu_op`  out  4  ALU operation code.
- `imm_sel`  out  1  1 = B operand comes from `imm`.
- `imm`  out  16  extended immediate.
- `psr`  out  5  latched {C,L,F,Z,N}.
- `halted`  out  1  HALT executed.
- `instr_done`  out  1  one-cycle pulse per retired instruction.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- IDLE→FETCH when `enable`. FETCH: `imem_req`=1; on `imem_valid`, latch `imem_data` into IR and go to DECODE. DECODE→EXECUTE. EXECUTE→WRITEBACK. WRITEBACK→FETCH, with PC update and `instr_done` pulse.
- Decode fields: op=[15:12], Rdest=[11:8], ext=[7:4], Rsrc=[3:0], imm8=[7:0].
- R-type (op 0000): `alu_op`=ext, `rf_asel`=Rdest, `rf_bsel`=Rsrc, `imm_sel`=0. Valid ext values: ADD 0101, SUB 1001, CMP 1011, AND 0001, OR 0010, XOR 0011, MOV 1101.
- Immediate (op = same codes, or LUI 1111): `alu_op`=op, `imm_sel`=1.
  - ANDI/ORI/XORI: `imm` is imm8 zero-extended.
  - LUI: `imm` = {imm8, 8'h00}; `alu_op`=1101 (MOV).
  - Others: `imm` is imm8 sign-extended.
- `rf_wsel`=Rdest always. `rf_we`=1 only in WRITEBACK, with `enable` high, for non-CMP ALU instructions.
- PSR: loaded from `alu_flags` in WRITEBACK for ADD/SUB/CMP (R and I forms). Unchanged otherwise.
- IR 16'h0000 is HALT: WRITEBACK→HALT, `halted`=1, PC unchanged. HALT exits only via `rst`.
- Unlisted opcodes/ext values: NOP. No write, no PSR change, PC+1, `instr_done` still pulses.
- PC update: PC+1 (16-bit, wraps FFFF→0000). Taken branch: PC + sext(imm8), mod 2^16.
- Bcond (op 1100), cond=[11:8]:
  - EQ 0 Z; NE 1 !Z; CS 2 C; CC 3 !C; HI 4 L; LS 5 !L; GT 6 N; LE 7 !N.
  - FS 8 F; FC 9 !F; LO A !L&!Z; HS B L|Z; LT C !N&!Z; GE D N|Z; UC E always; F never.
  - Conditions are evaluated on `psr` in WRITEBACK.
- Selects and `imm` are registered, valid from EXECUTE through WRITEBACK, and hold their value in FETCH/DECODE.

## Timing
- Reset values: state IDLE, `pc`=RESET_PC, all other outputs 0, IR 0.
- `imem_req` is a Moore output (state==FETCH). `imem_valid` may arrive in the same cycle or later. While waiting, `pc` and `imem_req` stay stable.
- Minimum 4 cycles per instruction with zero-wait memory.
- `enable` low in any state freezes state, PC, IR and PSR. `rf_we` and `instr_done` are forced to 0. `imem_valid` is ignored while `enable` is low.
- `rst` mid-instruction aborts immediately. No `rf_we` occurs after the `rst` edge.
- CMP followed by Bcond: the branch sees the flags written in the CMP's WRITEBACK.

## Configuration
- `CR16_BCOND_EN` defined: Bcond decoded and executed as above.
- `CR16_BCOND_EN` undefined: op 1100 is a NOP (PC+1, no write). The branch-condition logic is not built. PSR latching is unchanged.

## Test plan
- Reset with RESET_PC=16'h0010, then `enable`=1 -> `imem_req`=1 with `pc`=0010 on the 2nd cycle after reset release; all other outputs 0 during reset.
- Zero-wait MOVI R3,#-2 (16'hD3FE) -> EXECUTE: `imm`=FFFE, `imm_sel`=1, `rf_wsel`=3; WRITEBACK: `rf_we`=1 for 1 cycle; `pc`=0011; 4 cycles total.
- ORI R1,#80 (16'h2180) -> `imm`=0080 (zero-extended). LUI R2,#12 (16'hF212) -> `imm`=1200.
- CMP R1,R2 (16'h01B2) with `alu_flags`=00010 -> no `rf_we`, `psr`=00010. Then BEQ -4 (16'hC0FC) at pc 0020 -> `pc`=001C. Repeat with `psr` Z=0 -> `pc`=0021.
- `imem_valid` delayed 3 cycles with `enable` dropped for 2 cycles inside EXECUTE -> outputs frozen, single `rf_we` pulse, exactly one `instr_done`.
- 16'h0000 fetched -> `halted`=1, `imem_req` stays 0 indefinitely; `rst` pulse -> back to IDLE, `halted`=0. Without `CR16_BCOND_EN`, 16'hCEFC -> `pc`+1.

Source files
------------

// File: rtl/cr16_controller.sv
// cr16_controller: multicycle fetch/decode/execute/writeback control FSM for the CR16 datapath.
// Define CR16_BCOND_EN to build Bcond decode and execution; otherwise op 1100 behaves as a NOP.
module cr16_controller #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        imem_valid,
   input  logic [15:0] imem_data,
   input  logic [4:0]  alu_flags,
   output logic        imem_req,
   output logic [15:0] pc,
   output logic        rf_we,
   output logic [3:0]  rf_wsel,
   output logic [3:0]  rf_asel,
   output logic [3:0]  rf_bsel,
   output logic [3:0]  alu_op,
   output logic        imm_sel,
   output logic [15:0] imm,
   output logic [4:0]  psr,
   output logic        halted,
   output logic        instr_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
   } state_t;

   localparam logic [3:0] OP_AND = 4'b0001;
   localparam logic [3:0] OP_OR  = 4'b0010;
   localparam logic [3:0] OP_XOR = 4'b0011;
   localparam logic [3:0] OP_ADD = 4'b0101;
   localparam logic [3:0] OP_SUB = 4'b1001;
   localparam logic [3:0] OP_CMP = 4'b1011;
   localparam logic [3:0] OP_MOV = 4'b1101;
   localparam logic [3:0] OP_LUI = 4'b1111;

   state_t      r_state;
   logic [15:0] r_ir;
   logic [15:0] r_pc;
   logic [4:0]  r_psr;
   logic        r_req;
   logic [3:0]  r_wsel, r_asel, r_bsel, r_alu_op;
   logic        r_imm_sel;
   logic [15:0] r_imm;
   logic        r_we_pend;
   logic        r_psr_upd;
   logic        r_is_br;
   logic        r_halted;

   logic [3:0]  w_op, w_rdest, w_ext, w_rsrc;
   logic [7:0]  w_imm8;
   logic [15:0] w_sext, w_zext;
   logic [3:0]  w_alu_op;
   logic        w_imm_sel;
   logic [15:0] w_imm;
   logic        w_we;
   logic        w_psr_upd;
   logic        w_branch;
   logic        w_halt;
   logic        w_taken;
   logic        w_in_wb;

   function automatic logic is_alu_code(input logic [3:0] code);
      return code inside {OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_CMP, OP_MOV};
   endfunction

   assign w_op    = r_ir[15:12];
   assign w_rdest = r_ir[11:8];
   assign w_ext   = r_ir[7:4];
   assign w_rsrc  = r_ir[3:0];
   assign w_imm8  = r_ir[7:0];
   assign w_sext  = {{8{w_imm8[7]}}, w_imm8};
   assign w_zext  = {8'h00, w_imm8};
   assign w_halt  = (r_ir == 16'h0000);

   // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_alu_op  = 4'h0;
      w_imm_sel = 1'b0;
      w_imm     = 16'h0000;
      w_we      = 1'b0;
      w_psr_upd = 1'b0;
      w_branch  = 1'b0;
      if (w_op == 4'b0000) begin
         if (is_alu_code(w_ext)) begin
            w_alu_op  = w_ext;
            w_we      = (w_ext != OP_CMP);
            w_psr_upd = w_ext inside {OP_ADD, OP_SUB, OP_CMP};
         end
      end else if (w_op == OP_LUI) begin
         w_alu_op  = OP_MOV;
         w_imm_sel = 1'b1;
         w_imm     = {w_imm8, 8'h00};
         w_we      = 1'b1;
      end else if (is_alu_code(w_op)) begin
         w_alu_op  = w_op;
         w_imm_sel = 1'b1;
         w_imm     = (w_op inside {OP_AND, OP_OR, OP_XOR}) ? w_zext : w_sext;
         w_we      = (w_op != OP_CMP);
         w_psr_upd = w_op inside {OP_ADD, OP_SUB, OP_CMP};
      end
`ifdef CR16_BCOND_EN
      else if (w_op == 4'b1100) begin
         w_branch = 1'b1;
         w_imm    = w_sext;
      end
`endif
   end

`ifdef CR16_BCOND_EN
   logic w_cond_true;

   // Condition field shares the Rdest slot; psr is {C,L,F,Z,N}.
   always_comb begin
      w_cond_true = 1'b0;
      case (w_rdest)
         4'h0: w_cond_true =  r_psr[1];
         4'h1: w_cond_true = ~r_psr[1];
         4'h2: w_cond_true =  r_psr[4];
         4'h3: w_cond_true = ~r_psr[4];
         4'h4: w_cond_true =  r_psr[3];
         4'h5: w_cond_true = ~r_psr[3];
         4'h6: w_cond_true =  r_psr[0];
         4'h7: w_cond_true = ~r_psr[0];
         4'h8: w_cond_true =  r_psr[2];
         4'h9: w_cond_true = ~r_psr[2];
         4'hA: w_cond_true = ~r_psr[3] & ~r_psr[1];
         4'hB: w_cond_true =  r_psr[3] |  r_psr[1];
         4'hC: w_cond_true = ~r_psr[0] & ~r_psr[1];
         4'hD: w_cond_true =  r_psr[0] |  r_psr[1];
         4'hE: w_cond_true = 1'b1;
         default: w_cond_true = 1'b0;
      endcase
   end

   assign w_taken = r_is_br & w_cond_true;
`else
   // r_is_br is never set in this build, so branches are never taken.
   assign w_taken = r_is_br;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_ir      <= 16'h0000;
         r_pc      <= RESET_PC;
         r_psr     <= 5'b00000;
         r_req     <= 1'b0;
         r_wsel    <= 4'h0;
         r_asel    <= 4'h0;
         r_bsel    <= 4'h0;
         r_alu_op  <= 4'h0;
         r_imm_sel <= 1'b0;
         r_imm     <= 16'h0000;
         r_we_pend <= 1'b0;
         r_psr_upd <= 1'b0;
         r_is_br   <= 1'b0;
         r_halted  <= 1'b0;
      end else if (enable) begin
         case (r_state)
            S_IDLE: begin
               r_state <= S_FETCH;
               r_req   <= 1'b1;
            end
            S_FETCH: begin
               if (imem_valid) begin
                  r_ir    <= imem_data;
                  r_req   <= 1'b0;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               r_wsel    <= w_rdest;
               r_asel    <= w_rdest;
               r_bsel    <= w_rsrc;
               r_alu_op  <= w_alu_op;
               r_imm_sel <= w_imm_sel;
               r_imm     <= w_imm;
               r_we_pend <= w_we;
               r_psr_upd <= w_psr_upd;
               r_is_br   <= w_branch;
               r_state   <= S_EXECUTE;
            end
            S_EXECUTE: r_state <= S_WRITEBACK;
            S_WRITEBACK: begin
               if (r_psr_upd) r_psr <= alu_flags;
               if (w_halt) begin
                  r_state  <= S_HALT;
                  r_halted <= 1'b1;
               end else begin
                  r_state <= S_FETCH;
                  r_req   <= 1'b1;
                  r_pc    <= w_taken ? r_pc + r_imm : r_pc + 16'd1;
               end
            end
            S_HALT:  r_state <= S_HALT;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Strobes are gated by enable combinationally so a stalled WRITEBACK produces exactly one pulse.
   assign w_in_wb    = (r_state == S_WRITEBACK);
   assign rf_we      = w_in_wb & r_we_pend & enable;
   assign instr_done = w_in_wb & enable;

   assign imem_req = r_req;
   assign pc       = r_pc;
   assign rf_wsel  = r_wsel;
   assign rf_asel  = r_asel;
   assign rf_bsel  = r_bsel;
   assign alu_op   = r_alu_op;
   assign imm_sel  = r_imm_sel;
   assign imm      = r_imm;
   assign psr      = r_psr;
   assign halted   = r_halted;

endmodule
